clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Multi-channel, runtime-programmable clock divider. It generates NUM_CH divided clock/strobe
//  pairs from the core clock, for peripheral baud/tick generation in the SoC. Each channel
//  supports even and odd divisors, glitch-free divisor updates at period boundaries, and
//  stop-at-period-end gating.
// PARAMETERS
//  NUM_CH      2     number of independent divider channels
//  DIV_W       16    divisor width per channel
//  RESET_DIV   1526  active and pending divisor of every channel after reset
// PORTS
//  clk        in   1             core clock, all state on posedge (except the optional negedge flop)
//  reset_n    in   1             asynchronous, active-low reset
//  en_i       in   NUM_CH        per-channel run request
//  div_wen_i  in   NUM_CH        per-channel divisor write strobe
//  div_i      in   NUM_CH*DIV_W  new divisors; channel k = div_i[k*DIV_W +: DIV_W]
//  div_o      out  NUM_CH*DIV_W  active divisor per channel (post-clamp)
//  clk_o      out  NUM_CH        divided clock, registered
//  tick_o     out  NUM_CH        1-cycle strobe per output period
// BEHAVIOUR
//  - Reset (async): cnt=0, state=IDLE, clk_o=0, tick_o=0, active=pending=RESET_DIV, no pending flag.
//  - Divisor D: a value <2 is clamped to 2 on write. Counter cnt runs 0..D-1, then wraps to 0.
//  - Waveform: clk_o=0 for cnt in [0, floor(D/2)-1] and clk_o=1 for the rest, i.e. ceil(D/2) high cycles.
//    clk_o is registered from next-cnt, so there is no combinational path to the output.
//  - tick_o=1 exactly in the cycle where state=RUN and cnt==D-1.
//  - FSM per channel:
//      IDLE     -> RUN on en_i=1. cnt starts at 0 on the next edge.
//      RUN      -> STOPPING on en_i=0. The current period always completes.
//      STOPPING -> IDLE at wrap, where cnt=0 and clk_o=0.
//      STOPPING -> RUN if en_i=1 again before the wrap, with no disturbance to the waveform.
//  - Divisor write: a div_wen_i pulse loads pending and sets the pending flag.
//    - At wrap, active<=pending and the flag clears.
//    - A write in the wrap cycle itself is used for the next period (bypass).
//    - In IDLE the write goes straight to active.
//    - Back-to-back writes: the last one wins.
//  - Reset mid-period: clk_o drops immediately (async). This is the only non-glitch-free event.
//  - Channels are fully independent and share only clk and reset_n.
// CONFIGURATION
//  CLKDIV_DUTY50_EN defined:
//    - For odd D, clk_o = pos_q & neg_q, where neg_q is pos_q re-sampled on negedge clk.
//    - This gives an exact 50% duty: high for D/2 cycles.
//    - Even D is unaffected, and neg_q is reset by reset_n.
//  CLKDIV_DUTY50_EN undefined:
//    - Posedge-only logic; odd D is high for ceil(D/2) cycles and low for floor(D/2).
// STRUCTURE
//  Package clkdiv_pkg:
//    - typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_STOPPING} ch_state_t
//    - localparam MIN_DIV = 2
//    - function clamp_div()
//  Sub-module clk_div_ch: a single channel (FSM, counter, pending/active registers, output flops).
//    The top instantiates it NUM_CH times in a generate loop and only slices the buses.
// TESTING
//  1. Reset values:
//     - Hold reset_n=0 -> clk_o=0, tick_o=0, div_o=every channel 1526.
//     - Release with en_i=0 -> the outputs stay there.
//  2. Even divisor:
//     - Write D=4 on ch0 in IDLE, then en_i[0]=1.
//     - Expect clk_o pattern 0,0,1,1 repeating; tick_o on every 4th cycle, aligned to the last high cycle.
//  3. Odd divisor D=5:
//     - Without the macro: low 2 / high 3 cycles.
//     - With CLKDIV_DUTY50_EN: high time 2.5 cycles, measured on the waveform.
//  4. Divisor update:
//     - Running D=4, write D=6 at cnt=1.
//     - The current period finishes at 4; the next periods are 6 (low 3 / high 3).
//     - div_o changes at the wrap.
//  5. Stop and restart:
//     - Deassert en_i at cnt=2 of D=8 -> the period completes and the channel parks with clk_o=0.
//     - Reassert en_i during STOPPING -> there is no gap in the waveform.
//  6. Clamp and async reset:
//     - Write D=0 -> div_o=2, clk_o toggles every cycle.
//     - Pulse reset_n low mid-period, asynchronous to clk -> clk_o=0 immediately, div_o=1526.
//  7. Channel independence: run ch0 at D=3 and ch1 at D=10 concurrently -> no interaction between them.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared types, constants and divisor clamp for clk_div_multi.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package clkdiv_pkg;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_RUN      = 2'd1,
        CH_STOPPING = 2'd2
    } ch_state_t;

    localparam logic [31:0] MIN_DIV = 32'd2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ============================================================================
// Module      : clk_div_ch
// Description : One divider channel: run/stop FSM, period counter, pending and
//               active divisor, registered clock and tick outputs.
//               Optional macro CLKDIV_DUTY50_EN gives exact 50% duty on odd D.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_ch
    import clkdiv_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 1526
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_div_wen,
    input  logic [DIV_W-1:0] i_div,
    output logic [DIV_W-1:0] o_div,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] C_RESET_DIV = DIV_W'(clamp_div(32'(RESET_DIV)));
    localparam logic [DIV_W-1:0] C_ONE       = DIV_W'(1);

    ch_state_t        r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_act, w_act_nxt;
    logic [DIV_W-1:0] r_pend, w_pend_nxt;
    logic             r_pflag, w_pflag_nxt;
    logic             r_clk, w_clk_nxt;
    logic             r_tick, w_tick_nxt;
    logic [DIV_W-1:0] w_div_cl;
    logic             w_wrap;

    assign w_div_cl = DIV_W'(clamp_div(32'(i_div)));
    assign w_wrap   = (r_state != CH_IDLE) && (r_cnt == (r_act - C_ONE));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_act_nxt   = r_act;
        w_pend_nxt  = r_pend;
        w_pflag_nxt = r_pflag;
        case (r_state)
            CH_IDLE: begin
                w_cnt_nxt = '0;
                if (i_div_wen) begin
                    w_act_nxt  = w_div_cl;
                    w_pend_nxt = w_div_cl;
                end
                if (i_en) begin
                    w_state_nxt = CH_RUN;
                end
            end
            CH_RUN, CH_STOPPING: begin
                if (w_wrap) begin
                    // A write landing on the wrap cycle bypasses pending
                    w_cnt_nxt   = '0;
                    w_pflag_nxt = 1'b0;
                    if (i_div_wen) begin
                        w_act_nxt  = w_div_cl;
                        w_pend_nxt = w_div_cl;
                    end else if (r_pflag) begin
                        w_act_nxt = r_pend;
                    end
                    w_state_nxt = i_en ? CH_RUN : CH_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (i_div_wen) begin
                        w_pend_nxt  = w_div_cl;
                        w_pflag_nxt = 1'b1;
                    end
                    w_state_nxt = i_en ? CH_RUN : CH_STOPPING;
                end
            end
            default: begin
                w_state_nxt = CH_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_clk_nxt  = (w_state_nxt != CH_IDLE) && (w_cnt_nxt >= (w_act_nxt >> 1));
        w_tick_nxt = (w_state_nxt == CH_RUN) && (w_cnt_nxt == (w_act_nxt - C_ONE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CH_IDLE;
            r_cnt   <= '0;
            r_act   <= C_RESET_DIV;
            r_pend  <= C_RESET_DIV;
            r_pflag <= 1'b0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_act   <= w_act_nxt;
            r_pend  <= w_pend_nxt;
            r_pflag <= w_pflag_nxt;
            r_clk   <= w_clk_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

`ifdef CLKDIV_DUTY50_EN
    logic r_neg;

    // Half-cycle delayed copy trims the leading half cycle off odd-D high phases
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= r_clk;
        end
    end

    assign o_clk = r_act[0] ? (r_clk & r_neg) : r_clk;
`else
    assign o_clk = r_clk;
`endif

    assign o_div  = r_act;
    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module      : clk_div_multi
// Description : NUM_CH independent runtime-programmable clock dividers.
//               Optional macro CLKDIV_DUTY50_EN (exact 50% duty on odd D).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_multi #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 1526
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       div_wen_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    output logic [NUM_CH*DIV_W-1:0] div_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_en      (en_i[g]),
            .i_div_wen (div_wen_i[g]),
            .i_div     (div_i[g*DIV_W +: DIV_W]),
            .o_div     (div_o[g*DIV_W +: DIV_W]),
            .o_clk     (clk_o[g]),
            .o_tick    (tick_o[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi with a per-period
//               waveform-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_multi;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 16;
    localparam int RESET_DIV = 1526;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       wen;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH*DIV_W-1:0] div_o;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       tick_o;

    int checks = 0;
    int errors = 0;

    // Reference model: each started period pushes its whole waveform into a queue
    bit               m_wave [NUM_CH][$];
    logic [DIV_W-1:0] m_act  [NUM_CH];
    logic [DIV_W-1:0] m_pend [NUM_CH];
    bit               m_pflag[NUM_CH];
    bit               m_busy [NUM_CH];
    logic             m_clk  [NUM_CH];
    logic             m_tick [NUM_CH];

    clk_div_multi #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (en),
        .div_wen_i (wen),
        .div_i     (div),
        .div_o     (div_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_act[k]   = DIV_W'(RESET_DIV);
            m_pend[k]  = DIV_W'(RESET_DIV);
            m_pflag[k] = 1'b0;
            m_busy[k]  = 1'b0;
            m_wave[k].delete();
            m_clk[k]   = 1'b0;
            m_tick[k]  = 1'b0;
        end
    endtask

    task automatic start_period(input int k);
        int d;
        bit v;
        d = int'(m_act[k]);
        m_wave[k].delete();
        for (int i = 0; i < d; i++) begin
            v = (i >= d / 2);
`ifdef CLKDIV_DUTY50_EN
            if ((d % 2 == 1) && (i == d / 2)) v = 1'b0;
`endif
            m_wave[k].push_back(v);
        end
        m_busy[k] = 1'b1;
        m_clk[k]  = m_wave[k].pop_front();
    endtask

    task automatic model_step();
        int dv;
        for (int k = 0; k < NUM_CH; k++) begin
            dv = int'(div[k*DIV_W +: DIV_W]);
            if (dv < 2) dv = 2;
            if (!m_busy[k]) begin
                if (wen[k]) m_act[k] = dv[DIV_W-1:0];
                if (en[k]) start_period(k);
                else m_clk[k] = 1'b0;
            end else if (m_wave[k].size() == 0) begin
                if (wen[k]) m_act[k] = dv[DIV_W-1:0];
                else if (m_pflag[k]) m_act[k] = m_pend[k];
                m_pflag[k] = 1'b0;
                if (en[k]) start_period(k);
                else begin
                    m_busy[k] = 1'b0;
                    m_clk[k]  = 1'b0;
                end
            end else begin
                if (wen[k]) begin
                    m_pend[k]  = dv[DIV_W-1:0];
                    m_pflag[k] = 1'b1;
                end
                m_clk[k] = m_wave[k].pop_front();
            end
            m_tick[k] = m_busy[k] && en[k] && (m_wave[k].size() == 0);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            assert (clk_o[k] === m_clk[k]) else begin
                errors++;
                $error("FAIL %s clk_o[%0d] t=%0t got %b expected %b", tag, k, $time, clk_o[k], m_clk[k]);
            end
            checks++;
            assert (tick_o[k] === m_tick[k]) else begin
                errors++;
                $error("FAIL %s tick_o[%0d] t=%0t got %b expected %b", tag, k, $time, tick_o[k], m_tick[k]);
            end
            checks++;
            assert (div_o[k*DIV_W +: DIV_W] === m_act[k]) else begin
                errors++;
                $error("FAIL %s div_o[%0d] t=%0t got %0d expected %0d", tag, k, $time, div_o[k*DIV_W +: DIV_W], m_act[k]);
            end
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic write_div(input int k, input int d, input string tag);
        wen[k] = 1'b1;
        div[k*DIV_W +: DIV_W] = DIV_W'(d);
        cyc(tag);
        wen[k] = 1'b0;
    endtask

    // Advance until channel k runs divisor d with rem cycles left after the current one
    task automatic wait_at(input int k, input int d, input int rem, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_busy[k] && int'(m_act[k]) == d && m_wave[k].size() == rem) hit = 1'b1;
            else cyc(tag);
        end
        checks++;
        assert (hit === 1'b1) else begin
            errors++;
            $error("FAIL %s wait: got no hit, expected D=%0d rem=%0d", tag, d, rem);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en      = '0;
        wen     = '0;
        div     = '0;
        model_reset();

        // Reset values held, then released with en low
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end
        reset_n = 1'b1;
        run(3, "idle");

        // Even divisor programmed in IDLE
        write_div(0, 4, "wr4");
        en[0] = 1'b1;
        run(12, "even4");

        // Odd divisor staged while running
        write_div(0, 5, "wr5");
        run(16, "odd5");

        // Mid-period update lands at the following wrap
        write_div(0, 4, "wr4b");
        wait_at(0, 4, 2, "upd_wait");
        write_div(0, 6, "wr6");
        run(16, "upd6");

        // Stop mid-period, then restart from STOPPING
        write_div(0, 8, "wr8");
        wait_at(0, 8, 5, "stop_wait");
        en[0] = 1'b0;
        run(10, "stop");
        en[0] = 1'b1;
        wait_at(0, 8, 3, "restart_wait");
        en[0] = 1'b0;
        run(2, "stopping");
        en[0] = 1'b1;
        run(12, "restart");

        // Clamp of zero divisor, then bypass write on the wrap cycle
        write_div(0, 0, "wr0");
        run(8, "clamp");
        write_div(0, 7, "wr7");
        wait_at(0, 7, 0, "wrap_wait");
        write_div(0, 3, "wr3_bypass");
        run(8, "bypass");

        // Asynchronous reset mid-period
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        en = '0;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset_n = 1'b1;
        run(2, "post_rst");

        // Two channels concurrently at different divisors
        write_div(0, 3, "wr_c0");
        write_div(1, 10, "wr_c1");
        en = 2'b11;
        run(40, "indep");

        // Random enables and writes on both channels
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 15) == 0) en[k] = ~en[k];
                wen[k] = ($urandom_range(0, 7) == 0);
                div[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
            end
            cyc("random");
        end
        wen = '0;
        en  = '0;
        run(20, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
